i2s_dac_serializer: RTL and testbench

//  Consumes signed 16-bit audio samples from the float-to-int conversion stage and streams them to the

---
 rtl/i2s_dac_serializer_pkg.sv | 20 ++
 rtl/i2s_bclk_gen.sv | 56 +++++
 rtl/i2s_dac_serializer.sv | 174 +++++++++++++++++
 tb/tb_i2s_dac_serializer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_dac_serializer_pkg.sv
// Shared constants, FSM state encoding and a counter-width helper for the
// I2S DAC serializer.
package i2s_dac_serializer_pkg;

  localparam int SAMPLE_WIDTH_DEF = 16;
  localparam int SLOT_BITS_DEF    = 32;
  localparam int BCLK_DIV_DEF     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } i2s_state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK generator: divides clk by 2*BCLK_DIV while enabled and flags the
// divider wrap that makes BCLK fall. While disabled the divider and BCLK
// are held at zero. skip_i lets a wrap pass without toggling BCLK.
module i2s_bclk_gen
  import i2s_dac_serializer_pkg::*;
#(
  parameter int BCLK_DIV = BCLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic skip_i,
  output logic bclk_o,
  output logic wrap_o,
  output logic fall_o
);

  localparam int CW = cnt_width(BCLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(BCLK_DIV - 1);

  logic [CW-1:0] div_q, div_d;
  logic          bclk_q, bclk_d;

  assign wrap_o = en_i && (div_q == DIV_LAST);
  assign fall_o = wrap_o && !skip_i && bclk_q;
  assign bclk_o = bclk_q;

  // Next divider count and BCLK level.
  always_comb begin
    div_d  = div_q;
    bclk_d = bclk_q;
    if (!en_i) begin
      div_d  = '0;
      bclk_d = 1'b0;
    end else if (wrap_o) begin
      div_d = '0;
      if (!skip_i) begin
        bclk_d = ~bclk_q;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Divider and BCLK registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

endmodule

// File: rtl/i2s_dac_serializer.sv
// I2S DAC serializer: takes mono signed samples and sends each one on both
// the left and right slot of a frame (MSB first, one BCLK after the LRCK
// edge). A one-entry pending register decouples the producer from the
// frame timing; when no new sample is ready at a frame boundary the last
// sample is repeated and underflow pulses.
//
// Handshake: a sample is taken on any clk edge where sample_valid and
// sample_ready are both high. sample_ready is high when the pending register
// is empty, and also on a frame-load cycle, because that load frees the
// pending register in the same edge that the new sample lands in it.
// sample_ready depends only on internal registers, never on sample_valid.
module i2s_dac_serializer
  import i2s_dac_serializer_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int SLOT_BITS    = SLOT_BITS_DEF,
  parameter int BCLK_DIV     = BCLK_DIV_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    aud_bclk,
  output logic                    aud_daclrck,
  output logic                    aud_dacdat,
  output logic                    frame_start,
  output logic                    underflow,
  output i2s_state_e              dbg_state_o
);

  localparam int BW = cnt_width(SLOT_BITS);
  localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(SAMPLE_WIDTH);

  i2s_state_e              state_q, state_d;
  logic                    start_q, start_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [SAMPLE_WIDTH-1:0] pend_q, pend_d;
  logic                    pend_full_q, pend_full_d;
  logic [SAMPLE_WIDTH-1:0] last_q, last_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic                    lrck_q, lrck_d;
  logic                    dat_q, dat_d;
  logic                    fs_q, fs_d;
  logic                    uf_q, uf_d;

  logic                    wrap, fall, load, accept;
  logic [BW-1:0]           bit_inc;
  logic [SAMPLE_WIDTH-1:0] shifted;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q != ST_IDLE),
    .skip_i (start_q),
    .bclk_o (aud_bclk),
    .wrap_o (wrap),
    .fall_o (fall)
  );

  // The first load after IDLE happens on the first divider wrap (BCLK held
  // low for it); every later load is the FALL that ends a RIGHT slot.
  assign load = ((state_q == ST_LEFT) && start_q && wrap) ||
                ((state_q == ST_RIGHT) && fall && (bit_q == BIT_LAST));

  assign sample_ready = !pend_full_q || load;
  assign accept       = sample_valid && sample_ready;

  // Bit k of the slot (k = 1..SAMPLE_WIDTH) carries shift_q[SAMPLE_WIDTH-k].
  assign bit_inc = bit_q + 1'b1;
  assign shifted = shift_q >> (DATA_LAST - bit_inc);

  // Next-state and output logic for the frame FSM and sample registers.
  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    bit_d       = bit_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    last_d      = last_q;
    shift_d     = shift_q;
    lrck_d      = lrck_q;
    dat_d       = dat_q;
    fs_d        = 1'b0;
    uf_d        = 1'b0;

    if (state_q == ST_IDLE) begin
      if (accept) begin
        pend_d      = sample_in;
        pend_full_d = 1'b1;
        state_d     = ST_LEFT;
        start_d     = 1'b1;
        bit_d       = '0;
      end
    end else if (load) begin
      state_d = ST_LEFT;
      start_d = 1'b0;
      bit_d   = '0;
      lrck_d  = 1'b0;
      dat_d   = 1'b0;
      fs_d    = 1'b1;
      if (pend_full_q) begin
        shift_d = pend_q;
        last_d  = pend_q;
        if (accept) begin
          pend_d = sample_in;
        end else begin
          pend_full_d = 1'b0;
        end
      end else if (sample_valid) begin
        shift_d = sample_in;
        last_d  = sample_in;
      end else begin
        shift_d = last_q;
        uf_d    = 1'b1;
      end
    end else begin
      if (accept) begin
        pend_d      = sample_in;
        pend_full_d = 1'b1;
      end
      if (fall) begin
        if (bit_q == BIT_LAST) begin
          bit_d   = '0;
          state_d = ST_RIGHT;
          lrck_d  = 1'b1;
          dat_d   = 1'b0;
        end else begin
          bit_d = bit_inc;
          dat_d = (bit_inc <= DATA_LAST) ? shifted[0] : 1'b0;
        end
      end
    end
  end

  // State, sample and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      bit_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      last_q      <= '0;
      shift_q     <= '0;
      lrck_q      <= 1'b1;
      dat_q       <= 1'b0;
      fs_q        <= 1'b0;
      uf_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      bit_q       <= bit_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      last_q      <= last_d;
      shift_q     <= shift_d;
      lrck_q      <= lrck_d;
      dat_q       <= dat_d;
      fs_q        <= fs_d;
      uf_q        <= uf_d;
    end
  end

  assign aud_daclrck = lrck_q;
  assign aud_dacdat  = dat_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Bench for i2s_dac_serializer: a frame-level model (sample queue plus frame
// timing arithmetic) checked every cycle, an I2S decoder on BCLK rising
// edges, and literal expectations for the directed scenarios.
module tb_i2s_dac_serializer;
  import i2s_dac_serializer_pkg::*;

  localparam int SW     = 16;
  localparam int SLOT   = 18;
  localparam int DIV    = 2;
  localparam int FRAME  = 2 * SLOT * 2 * DIV;
  localparam int SLOT6  = 17;
  localparam int DIV6   = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [SW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready, aud_bclk, aud_daclrck, aud_dacdat, frame_start, underflow;
  i2s_state_e    dbg_state;

  logic [SW-1:0] sample6 = '0;
  logic          valid6 = 1'b0;
  logic          ready6, bclk6, lrck6, dat6, fs6, uf6;
  i2s_state_e    dbg_state6;

  i2s_dac_serializer #(.SAMPLE_WIDTH(SW), .SLOT_BITS(SLOT), .BCLK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck),
    .aud_dacdat(aud_dacdat), .frame_start(frame_start), .underflow(underflow),
    .dbg_state_o(dbg_state)
  );

  i2s_dac_serializer #(.SAMPLE_WIDTH(SW), .SLOT_BITS(SLOT6), .BCLK_DIV(DIV6)) dut6 (
    .clk(clk), .reset(reset), .sample_in(sample6), .sample_valid(valid6),
    .sample_ready(ready6), .aud_bclk(bclk6), .aud_daclrck(lrck6),
    .aud_dacdat(dat6), .frame_start(fs6), .underflow(uf6),
    .dbg_state_o(dbg_state6)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: samples in frame order, pending slot, frame timing.
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] dec_q[$];
  int            fs_cycles[$];
  bit            m_started, m_pend_full, m_fs, m_uf;
  int            m_cnt, m_loads, uf_count, cyc;
  logic [SW-1:0] m_pend, m_last, m_s;
  logic          load_now, exp_ready, acc;

  // Serial decoder state.
  bit            d_active, d_prev_bclk, d_lrck, d_pad_bad;
  int            d_pos;
  logic [SW-1:0] d_word, d_left;

  task automatic model_reset();
    m_started = 0; m_pend_full = 0; m_fs = 0; m_uf = 0;
    m_cnt = 0; m_loads = 0; uf_count = 0;
    m_pend = '0; m_last = '0;
    exp_q.delete(); dec_q.delete(); fs_cycles.delete();
    d_active = 0; d_prev_bclk = 0; d_pos = 0; d_pad_bad = 0; d_word = '0;
  endtask

  task automatic finish_slot();
    check("slot_bit_count", d_pos, (d_lrck ? SLOT : SLOT));
    check("slot_pad_zero", d_pad_bad, 0);
    if (!d_lrck) begin
      d_left = d_word;
    end else begin
      check("right_eq_left", d_word, d_left);
      if (exp_q.size() == 0) begin
        check("frame_expected_present", 0, 1);
      end else begin
        check("frame_sample", d_left, exp_q.pop_front());
      end
      dec_q.push_back(d_left);
    end
  endtask

  // Compare process: model step and decoder, once per cycle on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      model_reset();
    end else begin
      load_now  = m_started && (m_cnt == 0);
      exp_ready = !m_pend_full || load_now;
      check("sample_ready", sample_ready, exp_ready);
      check("frame_start", frame_start, m_fs);
      check("underflow", underflow, m_uf);
      if (!m_started) begin
        check("idle_bclk", aud_bclk, 0);
        check("idle_lrck", aud_daclrck, 1);
        check("idle_dat", aud_dacdat, 0);
      end
      if (frame_start) fs_cycles.push_back(cyc);
      if (underflow) uf_count++;

      acc  = sample_valid && exp_ready;
      m_fs = 0;
      m_uf = 0;
      if (load_now) begin
        if (m_pend_full) begin
          m_s = m_pend;
          if (acc) m_pend = sample_in;
          else m_pend_full = 0;
        end else if (sample_valid) begin
          m_s = sample_in;
        end else begin
          m_s  = m_last;
          m_uf = 1;
        end
        m_last = m_s;
        exp_q.push_back(m_s);
        m_loads++;
        m_fs  = 1;
        m_cnt = FRAME - 1;
      end else begin
        if (m_started) m_cnt--;
        else if (acc) begin
          m_started = 1;
          m_cnt     = DIV - 1;
        end
        if (acc) begin
          m_pend      = sample_in;
          m_pend_full = 1;
        end
      end

      // I2S decode on BCLK rising edges.
      if (aud_bclk && !d_prev_bclk) begin
        if (!d_active || (aud_daclrck != d_lrck)) begin
          if (d_active) finish_slot();
          d_active  = 1;
          d_lrck    = aud_daclrck;
          d_pos     = 0;
          d_word    = '0;
          d_pad_bad = 0;
        end
        if (d_pos >= 1 && d_pos <= SW) d_word = {d_word[SW-2:0], aud_dacdat};
        else if (aud_dacdat) d_pad_bad = 1;
        d_pos++;
      end
      d_prev_bclk = aud_bclk;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_one(input logic [SW-1:0] v);
    @(posedge clk); #1;
    sample_valid = 1'b1;
    sample_in    = v;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  int            low, uf_before, loads_before, idx, c1, c2;
  bit            found, prev_l, per_ok, prev_b;
  logic [SW-1:0] val, w6;
  int            r_cyc[$];
  bit            r_l[$], r_d[$];
  int            fs6_c[$];

  initial begin
    // Reset state.
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", sample_ready, 1);
    check("rst_bclk", aud_bclk, 0);
    check("rst_lrck", aud_daclrck, 1);
    check("rst_dat", aud_dacdat, 0);
    check("rst_fs", frame_start, 0);
    check("rst_uf", underflow, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // Test 1: single sample 8001.
    send_one(16'h8001);
    low = 0;
    repeat (8) begin
      @(negedge clk);
      if (!sample_ready) low++;
    end
    check("t1_ready_low_cycles", low, 1);
    wait_cycles(2 * FRAME + 20);
    check("t1_fs_count_ge2", (fs_cycles.size() >= 2), 1);
    if (fs_cycles.size() >= 2) check("t1_frame_period", fs_cycles[1] - fs_cycles[0], FRAME);
    check("t1_decoded_ge1", (dec_q.size() >= 1), 1);
    if (dec_q.size() >= 1) check("t1_decoded_8001", dec_q[0], 16'h8001);

    // Test 2: no new samples -> repeat with underflow at each load.
    uf_before = uf_count;
    wait_cycles(3 * FRAME);
    check("t2_uf_per_frame", uf_count - uf_before, 3);
    if (dec_q.size() >= 1) check("t2_repeat_8001", dec_q[dec_q.size()-1], 16'h8001);

    // Test 3: valid held high with incrementing values (random start value).
    val = 16'($urandom_range(1, 16'h7000));
    uf_before = uf_count;
    loads_before = m_loads;
    @(posedge clk); #1;
    sample_valid = 1'b1;
    sample_in    = val;
    repeat (4 * FRAME) begin
      @(negedge clk);
      acc = sample_ready;
      @(posedge clk); #1;
      if (acc) begin
        val++;
        sample_in = val;
      end
    end
    sample_valid = 1'b0;
    check("t3_no_underflow", uf_count - uf_before, 0);
    check("t3_loads", m_loads - loads_before, 4);
    wait_cycles(2 * FRAME + 20);

    // Test 4: bypass on the load cycle with pending empty.
    found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk); #1;
      if (m_started && m_cnt == 0 && !m_pend_full) begin
        found = 1;
        break;
      end
    end
    check("t4_found_load_cycle", found, 1);
    idx = m_loads;
    if (found) begin
      sample_valid = 1'b1;
      sample_in    = 16'h7FFF;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      @(negedge clk);
      check("t4_fs", frame_start, 1);
      check("t4_no_uf", underflow, 0);
    end
    wait_cycles(2 * FRAME + 20);
    check("t4_decoded_present", (dec_q.size() > idx), 1);
    if (dec_q.size() > idx) check("t4_decoded_7fff", dec_q[idx], 16'h7FFF);

    // Test 5: reset mid-RIGHT with a sample sitting in pending.
    found  = 0;
    prev_l = aud_daclrck;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (aud_daclrck && !prev_l) begin
        found = 1;
        break;
      end
      prev_l = aud_daclrck;
    end
    check("t5_found_right", found, 1);
    send_one(16'h5555);
    wait_cycles(SLOT * DIV - 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_bclk", aud_bclk, 0);
    check("t5_lrck", aud_daclrck, 1);
    check("t5_dat", aud_dacdat, 0);
    check("t5_fs", frame_start, 0);
    check("t5_uf", underflow, 0);
    check("t5_ready", sample_ready, 1);
    check("t5_state", dbg_state, ST_IDLE);
    send_one(16'h1234);
    wait_cycles(3 * FRAME + 20);
    check("t5_decoded_ge2", (dec_q.size() >= 2), 1);
    if (dec_q.size() >= 2) begin
      check("t5_first_1234", dec_q[0], 16'h1234);
      check("t5_repeat_1234", dec_q[1], 16'h1234);
    end

    // Test 6: BCLK_DIV=1, SLOT_BITS=17 instance.
    @(posedge clk); #1;
    valid6  = 1'b1;
    sample6 = 16'hA5C3;
    @(posedge clk); #1;
    valid6 = 1'b0;
    prev_b = 0;
    for (int i = 0; i < 400 && r_cyc.size() < 60; i++) begin
      @(negedge clk);
      if (bclk6 && !prev_b) begin
        r_cyc.push_back(i);
        r_l.push_back(lrck6);
        r_d.push_back(dat6);
      end
      if (fs6) fs6_c.push_back(i);
      prev_b = bclk6;
    end
    check("t6_rises_collected", (r_cyc.size() >= 60), 1);
    if (r_cyc.size() >= 60) begin
      per_ok = 1;
      for (int j = 1; j < 60; j++) if (r_cyc[j] - r_cyc[j-1] != 2) per_ok = 0;
      check("t6_bclk_period_2", per_ok, 1);
      c1 = 0;
      c2 = 0;
      for (int j = 1; j < 60; j++) begin
        if (r_l[j] != r_l[j-1]) begin
          if (c1 == 0) c1 = j;
          else if (c2 == 0) c2 = j;
        end
      end
      check("t6_first_left", r_l[0], 0);
      check("t6_left_run_17", c1, SLOT6);
      check("t6_right_run_17", c2 - c1, SLOT6);
      if (c1 > 0 && c1 + SW < 60) begin
        check("t6_left_delay_bit", r_d[0], 0);
        w6 = '0;
        for (int b = 1; b <= SW; b++) w6 = {w6[SW-2:0], r_d[b]};
        check("t6_left_word", w6, 16'hA5C3);
        check("t6_right_delay_bit", r_d[c1], 0);
        w6 = '0;
        for (int b = 1; b <= SW; b++) w6 = {w6[SW-2:0], r_d[c1+b]};
        check("t6_right_word", w6, 16'hA5C3);
      end
    end
    check("t6_fs_count_ge2", (fs6_c.size() >= 2), 1);
    if (fs6_c.size() >= 2) check("t6_frame_period", fs6_c[1] - fs6_c[0], 2 * SLOT6 * 2 * DIV6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog: the sequence above is bounded; this only catches a stuck run.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
